// File: rtl/fir_sample_feeder_pkg.sv
// Shared widths, folding factor and feeder state encoding for the folded FIR.
package fir_sample_feeder_pkg;

  localparam int unsigned DATA_W = 10;
  localparam int unsigned COEF_W = 12;
  localparam int unsigned OUT_W  = 22;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned FOLD   = 5;
  localparam int unsigned PH_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // Sample memory write request.
  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  // Requested playback length limited to the memory depth.
  function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] l);
    return (l > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : l;
  endfunction

endpackage

// File: rtl/fir_sample_mem.sv
// Register-array sample store: synchronous write, asynchronous read (read sees pre-edge data).
module fir_sample_mem #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk100,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data_c
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk100) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data_c = mem_q[rd_addr];

endmodule

// File: rtl/fir_sample_feeder.sv
// Input stage of the folded FIR: plays stored samples out one per FOLD clocks with a phase index.
module fir_sample_feeder
  import fir_sample_feeder_pkg::*;
(
  input  logic              clk100,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W:0]   len,
  input  logic              start,
  input  logic              abort,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  output logic [PH_W-1:0]   phase,
  output logic              busy,
  output logic              done
);

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(FOLD - 1);

  state_e            state_q,  state_d;
  logic [ADDR_W:0]   addr_q,   addr_d;
  logic [ADDR_W:0]   len_q,    len_d;
  logic [PH_W-1:0]   phase_q,  phase_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              valid_q,  valid_d;
  logic              busy_q,   busy_d;
  logic              done_q,   done_d;

  logic [ADDR_W:0]   eff_len_c;
  logic [ADDR_W-1:0] rd_addr_c;
  logic [DATA_W-1:0] rd_data_c;
  wr_req_t           wr_req_c;

  assign wr_req_c  = '{en: wr_en, addr: wr_addr, data: wr_data};
  assign eff_len_c = clamp_len(len);

  fir_sample_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk100    (clk100),
    .wr_en     (wr_req_c.en),
    .wr_addr   (wr_req_c.addr),
    .wr_data   (wr_req_c.data),
    .rd_addr   (rd_addr_c),
    .rd_data_c (rd_data_c)
  );

  // Next-state and next-output logic for the playback FSM, phase and address counters.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    phase_d   = phase_q;
    sample_d  = sample_q;
    valid_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rd_addr_c = addr_q[ADDR_W-1:0];

    case (state_q)
      ST_IDLE: begin
        rd_addr_c = '0;
        if (start) begin
          if (eff_len_c != '0) begin
            state_d  = ST_RUN;
            sample_d = rd_data_c;
            valid_d  = 1'b1;
            phase_d  = '0;
            addr_d   = (ADDR_W+1)'(1);
            busy_d   = 1'b1;
            len_d    = eff_len_c;
          end else begin
            state_d = ST_FIN;
          end
        end
      end

      ST_RUN: begin
        if (abort) begin
          state_d  = ST_IDLE;
          addr_d   = '0;
          phase_d  = '0;
          sample_d = '0;
          busy_d   = 1'b0;
        end else if (phase_q != PH_LAST) begin
          phase_d = phase_q + PH_W'(1);
        end else if (addr_q < len_q) begin
          sample_d = rd_data_c;
          valid_d  = 1'b1;
          phase_d  = '0;
          addr_d   = addr_q + (ADDR_W+1)'(1);
        end else begin
          state_d  = ST_FIN;
          sample_d = '0;
          phase_d  = '0;
          busy_d   = 1'b0;
        end
      end

      ST_FIN: begin
        // done lands in the cycle after FIN unless the run is aborted.
        state_d  = ST_IDLE;
        addr_d   = '0;
        phase_d  = '0;
        sample_d = '0;
        busy_d   = 1'b0;
        done_d   = ~abort;
      end

      default: begin
        state_d  = ST_IDLE;
        addr_d   = '0;
        phase_d  = '0;
        sample_d = '0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      phase_q  <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      phase_q  <= phase_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign phase        = phase_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Randomized self-checking bench for fir_sample_feeder against a timeline-based reference model.
module tb_fir_sample_feeder;

  localparam int FOLD  = 5;
  localparam int DEPTH = 256;

  logic       clk100 = 1'b0;
  logic       rst    = 1'b0;
  logic       wr_en  = 1'b0;
  logic [7:0] wr_addr = '0;
  logic [9:0] wr_data = '0;
  logic [8:0] len     = '0;
  logic       start   = 1'b0;
  logic       abort   = 1'b0;
  logic [9:0] sample_out;
  logic       sample_valid;
  logic [2:0] phase;
  logic       busy;
  logic       done;

  fir_sample_feeder dut (
    .clk100       (clk100),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .len          (len),
    .start        (start),
    .abort        (abort),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .phase        (phase),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk100 = ~clk100;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a run is a timeline t = edges since the start edge.
  logic [9:0] m_mem [DEPTH];
  bit         m_active = 1'b0;
  int         m_t      = 0;
  int         m_eff    = 0;
  logic [9:0] e_sample = '0;
  bit         e_valid  = 1'b0;
  int         e_phase  = 0;
  bit         e_busy   = 1'b0;
  bit         e_done   = 1'b0;

  task automatic model_edge();
    int total;
    if (m_active) begin
      if (abort) m_active = 1'b0;
      else       m_t++;
    end else if (start) begin
      m_eff    = (int'(len) > DEPTH) ? DEPTH : int'(len);
      m_t      = 0;
      m_active = 1'b1;
    end
    e_valid = 1'b0;
    e_done  = 1'b0;
    if (m_active) begin
      total = m_eff * FOLD;
      if (m_t < total) begin
        e_phase = m_t % FOLD;
        e_busy  = 1'b1;
        e_valid = (e_phase == 0);
        if (e_valid) e_sample = m_mem[m_t / FOLD];
      end else begin
        e_sample = '0;
        e_phase  = 0;
        e_busy   = 1'b0;
        if (m_t == total + 1) begin
          e_done   = 1'b1;
          m_active = 1'b0;
        end
      end
    end else begin
      e_sample = '0;
      e_phase  = 0;
      e_busy   = 1'b0;
    end
    // The sample read on this edge used the pre-edge memory contents.
    if (wr_en) m_mem[wr_addr] = wr_data;
  endtask

  // Per-run capture for scenario-level checks.
  int         cyc      = 0;
  int         vcount   = 0;
  int         done_cyc = -1;
  logic [9:0] vq[$];

  task automatic clear_cap();
    cyc      = -1;
    vcount   = 0;
    done_cyc = -1;
    vq.delete();
  endtask

  task automatic tick();
    @(posedge clk100);
    model_edge();
    #1;
    cyc++;
    check_eq("sample_out",   32'(sample_out),   32'(e_sample));
    check_eq("sample_valid", 32'(sample_valid), 32'(e_valid));
    check_eq("phase",        32'(phase),        32'(e_phase));
    check_eq("busy",         32'(busy),         32'(e_busy));
    check_eq("done",         32'(done),         32'(e_done));
    if (sample_valid) begin
      vcount++;
      vq.push_back(sample_out);
    end
    if (done) done_cyc = cyc;
  endtask

  task automatic wr(input logic [7:0] a, input logic [9:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic start_run(input logic [8:0] l);
    clear_cap();
    len = l; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_done(input int limit);
    for (int i = 0; i < limit && done_cyc < 0; i++) tick();
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_sample"}, 32'(sample_out),   32'd0);
    check_eq({tag, "_valid"},  32'(sample_valid), 32'd0);
    check_eq({tag, "_phase"},  32'(phase),        32'd0);
    check_eq({tag, "_busy"},   32'(busy),         32'd0);
    check_eq({tag, "_done"},   32'(done),         32'd0);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] exp_b [4];
    exp_b = '{10'h001, 10'h3FF, 10'h200, 10'h155};

    // Power-on reset.
    #2 rst = 1'b1;
    #1 check_idle_outputs("reset");
    repeat (2) @(negedge clk100);
    rst = 1'b0;

    // Basic playback of four samples.
    for (int i = 0; i < 4; i++) wr(8'(i), exp_b[i]);
    start_run(9'd4);
    run_to_done(40);
    check_eq("basic_count", 32'(vcount), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < vq.size()) check_eq("basic_seq", 32'(vq[i]), 32'(exp_b[i]));
    check_eq("basic_done_cyc", 32'(done_cyc), 32'd21);

    // Asynchronous reset in the third sample period, phase 2.
    start_run(9'd4);
    repeat (12) tick();
    check_eq("prerst_phase", 32'(phase), 32'd2);
    #3 rst = 1'b1;
    #1 check_idle_outputs("midrst");
    m_active = 1'b0; e_sample = '0; e_phase = 0; e_busy = 1'b0; e_valid = 1'b0;
    @(negedge clk100);
    rst = 1'b0;
    start_run(9'd2);
    run_to_done(30);
    check_eq("rst_restart_first", 32'(vq.size() > 0 ? vq[0] : 10'h2AB), 32'h001);
    check_eq("rst_restart_count", 32'(vcount), 32'd2);

    // Full depth with mem[i] = i.
    for (int i = 0; i < DEPTH; i++) wr(8'(i), 10'(i));
    start_run(9'd256);
    run_to_done(1400);
    check_eq("full_count", 32'(vcount), 32'd256);
    check_eq("full_last", 32'(vq.size() > 0 ? vq[vq.size()-1] : 10'h2AB), 32'd255);
    check_eq("full_done_cyc", 32'(done_cyc), 32'd1281);

    // Zero length: no valid, done one cycle after start.
    start_run(9'd0);
    run_to_done(10);
    check_eq("len0_count", 32'(vcount), 32'd0);
    check_eq("len0_done_cyc", 32'(done_cyc), 32'd1);

    // Length above depth clamps to 256 samples.
    start_run(9'd300);
    run_to_done(1400);
    check_eq("len300_count", 32'(vcount), 32'd256);
    check_eq("len300_done_cyc", 32'(done_cyc), 32'd1281);

    // Abort in the sample 2 period, then restart.
    start_run(9'd6);
    repeat (11) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_sample", 32'(sample_out), 32'd0);
    repeat (40) tick();
    check_eq("abort_no_done", 32'(done_cyc), 32'hFFFF_FFFF);
    start_run(9'd3);
    run_to_done(30);
    check_eq("abort_restart_first", 32'(vq.size() > 0 ? vq[0] : 10'h2AB), 32'd0);
    check_eq("abort_restart_count", 32'(vcount), 32'd3);

    // Write colliding with the read of mem[5].
    start_run(9'd8);
    repeat (24) tick();
    wr_en = 1'b1; wr_addr = 8'd5; wr_data = 10'h0AA;
    tick();
    wr_en = 1'b0;
    check_eq("coll_old", 32'(sample_out), 32'd5);
    run_to_done(40);
    start_run(9'd8);
    run_to_done(60);
    check_eq("coll_new", 32'(vq.size() > 5 ? vq[5] : 10'h2AB), 32'h0AA);

    // Start held high during RUN is ignored.
    clear_cap();
    len = 9'd3; start = 1'b1;
    tick();
    len = 9'd200;
    repeat (13) tick();
    start = 1'b0;
    run_to_done(20);
    check_eq("startrun_count", 32'(vcount), 32'd3);
    check_eq("startrun_done_cyc", 32'(done_cyc), 32'd16);

    // Fully random traffic checked every cycle by the model.
    for (int i = 0; i < 2500; i++) begin
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = 8'($urandom_range(0, 255));
      wr_data = 10'($urandom);
      abort   = ($urandom_range(0, 60) == 0);
      start   = ($urandom_range(0, 5) == 0);
      len     = ($urandom_range(0, 15) == 0) ? 9'(300) : 9'($urandom_range(0, 12));
      tick();
    end
    wr_en = 1'b0; abort = 1'b0; start = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
